alu_control_md: RTL and testbench
=================================

# alu_control_md

EX-stage ALU control for the pipelined datapath, generalised to `DATA_W`-bit operands. It adds an iterative unsigned multiply/divide unit with HI/LO registers. It keeps the existing `aluOp`/`func` decode to a 4-bit ALU select. It adds MULTU/DIVU/MFHI/MFLO, and raises a pipeline stall while a multi-cycle operation runs in EX.

## Interface
Parameters:
- `DATA_W`, 32, operand/HI/LO width; legal range 2..64.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `aluOp`  in  4  main-control ALU operation class.
- `func`  in  6  R-type function field.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `flush`  in  1  cancel EX instruction, including any in-flight mul/div.
- `a`  in  DATA_W  rs operand.
- `b`  in  DATA_W  rt operand.
- `out`  out  4  ALU select (combinational).
- `illegal`  out  1  no decode match (combinational).
- `stall`  out  1  hold IF/ID/EX; combinational from state and inputs.
- `hi`  out  DATA_W  HI register.
- `lo`  out  DATA_W  LO register.
- `div0`  out  1  last DIVU had `b`==0; registered.

## Operation
- Decode is combinational and must be registered-free.
  - `aluOp` classes map as follows:
    - 0100 → 0000 ADD
    - 1010 → 0001 SUB
    - 0010 → 0101 SLT
    - 1100 → 0010 AND
    - 1110 → 0100 OR
    - 1111 → 1111 BGEZ
    - 0101 → 0110 BEQ
    - 0111 → 0111 BNE
  - With `aluOp`=0000 (R-type), `func` maps as follows:
    - 100000 → 0000
    - 100010 → 0001
    - 100100 → 0010
    - 100111 → 0011
    - 100101 → 0100
    - 101010 → 0101
    - 010000 MFHI → 1000
    - 010010 MFLO → 1001
    - 011001 MULTU → 1010
    - 011011 DIVU → 1011
  - Any other combination → `out`=1110, `illegal`=1. `illegal` is 0 otherwise.
- md_issue = `ex_valid` & !`flush` & (`out`==1010 | `out`==1011).
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: if md_issue, go to BUSY. On that edge, latch `a`, `b` and the op, and load the iteration counter with `DATA_W`.
  - BUSY: one radix-2 step per cycle and counter decrements. When counter reaches 1, the final step writes `hi`/`lo` and the state moves to DONE.
  - DONE: lasts exactly one cycle, with `stall`=0. The held MULTU/DIVU in EX retires and is not reissued. Next state is IDLE.
- `stall` = (IDLE & md_issue) | BUSY.
- MULTU: unsigned shift-add. The 2·`DATA_W` product gives `hi`=upper half and `lo`=lower half.
- DIVU: unsigned restoring division. Results are `lo`=quotient and `hi`=remainder.
- DIVU with `b`==0: run full latency. Result is `lo`=all ones, `hi`=`a`, `div0`=1.
- `div0` is written only at DIVU completion. It clears to 0 at any MULTU completion.
- `hi`/`lo` change only at the completing edge. Intermediate values live in internal working registers.
- `flush` in BUSY: next state IDLE; `hi`/`lo`/`div0` unchanged; `stall` deasserts the following cycle. `flush` in IDLE blocks issue.
- Counter width is clog2(`DATA_W`+1); there is no wrap-around.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State IDLE, counter 0, `hi`=0, `lo`=0, `div0`=0.
  - `stall` follows its equation, so it is 0 unless md_issue is present.
  - Reset overrides everything, including mid-operation; partial results are discarded.
- Issue cycle T0: `stall`=1.
- Cycles T1..T`DATA_W` are BUSY with `stall`=1. `hi`/`lo` become valid after the edge ending T`DATA_W`.
- Cycle T`DATA_W`+1 is DONE with `stall`=0.
- Total stall is `DATA_W`+1 cycles per MULTU/DIVU.
- A MULTU/DIVU arriving in the cycle after DONE issues normally, so back-to-back ops are allowed.
- MFHI/MFLO in DONE+1 observe the new `hi`/`lo`.
- Simultaneous `flush` and the completing step: `flush` wins; `hi`/`lo` are not written.

## Test plan
- Decode sweep, `DATA_W`=32:
  - Every listed `aluOp`/`func` pair produces its listed `out` with `illegal`=0.
  - `aluOp`=0000 with `func`=111111 → `out`=1110, `illegal`=1, `stall`=0.
- MULTU, `DATA_W`=32: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF.
  - `stall` high for exactly 33 cycles.
  - Then `hi`=0xFFFFFFFE, `lo`=0x00000001, `div0`=0.
- DIVU, `DATA_W`=8: `a`=200, `b`=7.
  - `stall` high for 9 cycles.
  - Then `lo`=28, `hi`=4.
  - A following DIVU with `b`=0 and `a`=0x55 gives `lo`=0xFF, `hi`=0x55, `div0`=1.
- Flush mid-operation: MULTU 3×5 issued, `flush` asserted in BUSY cycle 4.
  - `stall`=0 from the next cycle.
  - `hi`/`lo` keep their prior values (0/0 after reset).
  - No completion occurs.
- Reset mid-operation: `rst_n`=0 during BUSY cycle 10 of DIVU.
  - Next cycle: state IDLE, `hi`=`lo`=0, `div0`=0, `stall`=0.
- Back-to-back, `DATA_W`=8:
  - MULTU 12×11 (`hi`=0, `lo`=132), then DIVU 100/9 issued in the cycle after DONE.
  - Result `lo`=11, `hi`=1; the second op's `stall` begins immediately after DONE.
  - MFLO in the following cycle gives `out`=1001 and sees `lo`=11.

Source files
------------

// File: rtl/alu_control_md.sv
// alu_control_md
// EX-stage ALU control with an iterative unsigned multiply/divide unit.
//
// Decodes the main-control ALU class (aluOp) and R-type function field (func)
// into a 4-bit ALU select. MULTU/DIVU start a DATA_W-step radix-2 operation
// whose results land in the HI/LO registers; the pipeline is stalled while it
// runs.
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     synchronous reset, active-low
//   aluOp     main-control ALU operation class (4)
//   func      R-type function field (6)
//   ex_valid  EX stage holds a valid instruction
//   flush     cancel EX instruction, including an in-flight mul/div
//   a, b      rs / rt operands (DATA_W)
//   out       ALU select (combinational)
//   illegal   no decode match (combinational)
//   stall     hold IF/ID/EX while a mul/div is issuing or running
//   hi, lo    HI/LO result registers (DATA_W)
//   div0      last DIVU had a zero divisor (registered)

module alu_control_md #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        aluOp,
  input  logic [5:0]        func,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [3:0]        out,
  output logic              illegal,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div0
);

  localparam int              CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DATA_W);
  localparam logic [3:0]      SEL_MULTU  = 4'b1010;
  localparam logic [3:0]      SEL_DIVU   = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;

  // Working registers: r_acc is the running high half (MULTU) or partial
  // remainder (DIVU); r_q is the multiplier shifting out / product low half
  // shifting in (MULTU) or dividend shifting out / quotient shifting in (DIVU).
  logic               r_is_div;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_q;
  logic [DATA_W-1:0]  r_b;

  logic               w_md_issue;
  logic               w_last;
  logic               w_complete;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W:0]    w_shift;
  logic [DATA_W-1:0]  w_diff;
  logic               w_ge;
  logic [DATA_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0]  w_q_nxt;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    out     = 4'b1110;
    illegal = 1'b1;
    unique case (aluOp)
      4'b0100: begin out = 4'b0000; illegal = 1'b0; end
      4'b1010: begin out = 4'b0001; illegal = 1'b0; end
      4'b0010: begin out = 4'b0101; illegal = 1'b0; end
      4'b1100: begin out = 4'b0010; illegal = 1'b0; end
      4'b1110: begin out = 4'b0100; illegal = 1'b0; end
      4'b1111: begin out = 4'b1111; illegal = 1'b0; end
      4'b0101: begin out = 4'b0110; illegal = 1'b0; end
      4'b0111: begin out = 4'b0111; illegal = 1'b0; end
      4'b0000: begin
        unique case (func)
          6'b100000: begin out = 4'b0000; illegal = 1'b0; end
          6'b100010: begin out = 4'b0001; illegal = 1'b0; end
          6'b100100: begin out = 4'b0010; illegal = 1'b0; end
          6'b100111: begin out = 4'b0011; illegal = 1'b0; end
          6'b100101: begin out = 4'b0100; illegal = 1'b0; end
          6'b101010: begin out = 4'b0101; illegal = 1'b0; end
          6'b010000: begin out = 4'b1000; illegal = 1'b0; end
          6'b010010: begin out = 4'b1001; illegal = 1'b0; end
          6'b011001: begin out = SEL_MULTU; illegal = 1'b0; end
          6'b011011: begin out = SEL_DIVU; illegal = 1'b0; end
          default:   begin out = 4'b1110; illegal = 1'b1; end
        endcase
      end
      default: begin out = 4'b1110; illegal = 1'b1; end
    endcase
  end

  assign w_md_issue = ex_valid & ~flush & ((out == SEL_MULTU) | (out == SEL_DIVU));
  assign w_last     = (r_state == S_BUSY) & (r_cnt == CNT_W'(1));
  // A flush coinciding with the final step cancels the write-back.
  assign w_complete = w_last & ~flush;

  // ---------------------------------------------------------------------------
  // FSM next state and stall
  // ---------------------------------------------------------------------------
  // DONE never issues: the MULTU/DIVU still held in EX retires that cycle.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_md_issue) begin
          w_state_nxt = S_BUSY;
          stall       = 1'b1;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step of the shared multiply/divide datapath
  // ---------------------------------------------------------------------------
  // MULTU: add the multiplicand when the multiplier LSB is set, then shift the
  // {acc, q} pair right by one; the carry becomes the new top bit of acc.
  assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  // DIVU: shift the next dividend bit into the remainder and subtract the
  // divisor when it fits. With a zero divisor every step "fits", so the
  // quotient fills with ones and the remainder ends up equal to the dividend.
  assign w_shift = {r_acc, r_q[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  // Only used when w_ge holds, where the difference is below r_b and fits.
  assign w_diff  = w_shift[DATA_W-1:0] - r_b;

  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_is_div) begin
      w_acc_nxt = w_ge ? w_diff : w_shift[DATA_W-1:0];
      w_q_nxt   = {r_q[DATA_W-2:0], w_ge};
    end else begin
      w_acc_nxt = w_sum[DATA_W:1];
      w_q_nxt   = {w_sum[0], r_q[DATA_W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_md_issue) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == S_BUSY) begin
        r_cnt <= flush ? '0 : r_cnt - 1'b1;
      end
      if (w_complete) begin
        hi   <= w_acc_nxt;
        lo   <= w_q_nxt;
        div0 <= r_is_div & (r_b == '0);
      end
    end
  end

  // NOTE: the working registers carry no reset; they are always loaded at
  // issue before being read, and reset only needs to return the FSM to IDLE.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_md_issue) begin
      r_is_div <= (out == SEL_DIVU);
      r_b      <= b;
      r_acc    <= '0;
      r_q      <= a;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md
// Directed bench for alu_control_md. Two instances: DATA_W=32 (decode, wide
// MULTU, flush and reset mid-operation) and DATA_W=8 (DIVU, divide-by-zero,
// back-to-back ops). Expected values are queued when stimulus is applied and
// popped when the corresponding output is observed.

module tb_alu_control_md;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  aluOp;
  logic [5:0]  func;

  logic        rst32_n, ev32, fl32;
  logic [31:0] a32, b32;
  logic [3:0]  out32;
  logic        ill32, stall32, div0_32;
  logic [31:0] hi32, lo32;

  logic        rst8_n, ev8, fl8;
  logic [7:0]  a8, b8;
  logic [3:0]  out8;
  logic        ill8, stall8, div0_8;
  logic [7:0]  hi8, lo8;

  alu_control_md #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .aluOp(aluOp), .func(func),
    .ex_valid(ev32), .flush(fl32), .a(a32), .b(b32),
    .out(out32), .illegal(ill32), .stall(stall32),
    .hi(hi32), .lo(lo32), .div0(div0_32)
  );

  alu_control_md #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .aluOp(aluOp), .func(func),
    .ex_valid(ev8), .flush(fl8), .a(a8), .b(b8),
    .out(out8), .illegal(ill8), .stall(stall8),
    .hi(hi8), .lo(lo8), .div0(div0_8)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] sel;
  } dec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  dec_t dec_tab [18];

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %0h expected <nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MULTU/DIVU and count cycles with stall high; returns in DONE.
  task automatic run_md(input bit is8, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv,
                        output int cycles);
    aluOp = 4'b0000;
    func  = fn;
    if (is8) begin
      a8 = av[7:0]; b8 = bv[7:0]; ev8 = 1'b1;
    end else begin
      a32 = av; b32 = bv; ev32 = 1'b1;
    end
    #1;
    cycles = 0;
    while ((is8 ? stall8 : stall32) && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;

    dec_tab = '{
      '{4'b0100, 6'b000000, 4'b0000}, '{4'b1010, 6'b000000, 4'b0001},
      '{4'b0010, 6'b000000, 4'b0101}, '{4'b1100, 6'b000000, 4'b0010},
      '{4'b1110, 6'b000000, 4'b0100}, '{4'b1111, 6'b000000, 4'b1111},
      '{4'b0101, 6'b000000, 4'b0110}, '{4'b0111, 6'b000000, 4'b0111},
      '{4'b0000, 6'b100000, 4'b0000}, '{4'b0000, 6'b100010, 4'b0001},
      '{4'b0000, 6'b100100, 4'b0010}, '{4'b0000, 6'b100111, 4'b0011},
      '{4'b0000, 6'b100101, 4'b0100}, '{4'b0000, 6'b101010, 4'b0101},
      '{4'b0000, F_MFHI,    4'b1000}, '{4'b0000, F_MFLO,    4'b1001},
      '{4'b0000, F_MULTU,   4'b1010}, '{4'b0000, F_DIVU,    4'b1011}
    };

    aluOp = 4'b0000; func = 6'b000000;
    rst32_n = 1'b0; ev32 = 1'b0; fl32 = 1'b0; a32 = '0; b32 = '0;
    rst8_n  = 1'b0; ev8  = 1'b0; fl8  = 1'b0; a8  = '0; b8  = '0;

    // Reset state
    repeat (2) tick();
    expect_v("rst_stall32", 0); chk(stall32);
    expect_v("rst_hi32", 0);    chk(hi32);
    expect_v("rst_lo32", 0);    chk(lo32);
    expect_v("rst_div0_32", 0); chk(div0_32);
    expect_v("rst_stall8", 0);  chk(stall8);
    expect_v("rst_hi8", 0);     chk(hi8);
    expect_v("rst_lo8", 0);     chk(lo8);
    expect_v("rst_div0_8", 0);  chk(div0_8);
    rst32_n = 1'b1; rst8_n = 1'b1;
    tick();

    // Decode sweep (ex_valid low so MULTU/DIVU entries do not issue)
    foreach (dec_tab[i]) begin
      aluOp = dec_tab[i].op;
      func  = dec_tab[i].fn;
      #1;
      expect_v($sformatf("dec_out_%0d", i), 64'(dec_tab[i].sel)); chk(out32);
      expect_v($sformatf("dec_ill_%0d", i), 0);                   chk(ill32);
    end

    // Illegal decodes, R-type and unknown class
    aluOp = 4'b0000; func = 6'b111111; ev32 = 1'b1;
    #1;
    expect_v("ill_rtype_out", 64'hE); chk(out32);
    expect_v("ill_rtype_ill", 1);     chk(ill32);
    expect_v("ill_rtype_stall", 0);   chk(stall32);
    aluOp = 4'b0001; func = 6'b100000;
    #1;
    expect_v("ill_class_out", 64'hE); chk(out32);
    expect_v("ill_class_ill", 1);     chk(ill32);
    ev32 = 1'b0;
    tick();

    // Flush in BUSY cycle 4 of MULTU 3x5
    aluOp = 4'b0000; func = F_MULTU; a32 = 32'd3; b32 = 32'd5; ev32 = 1'b1;
    #1;
    expect_v("fl_issue_stall", 1); chk(stall32);
    repeat (4) tick();
    fl32 = 1'b1; ev32 = 1'b0;
    #1;
    expect_v("fl_busy_stall", 1); chk(stall32);
    tick();
    fl32 = 1'b0;
    #1;
    expect_v("fl_after_stall", 0); chk(stall32);
    expect_v("fl_after_hi", 0);    chk(hi32);
    expect_v("fl_after_lo", 0);    chk(lo32);
    repeat (40) tick();
    expect_v("fl_late_stall", 0);  chk(stall32);
    expect_v("fl_late_hi", 0);     chk(hi32);
    expect_v("fl_late_lo", 0);     chk(lo32);
    expect_v("fl_late_div0", 0);   chk(div0_32);

    // MULTU 0xFFFFFFFF x 0xFFFFFFFF
    expect_v("mul32_stall", 33);
    expect_v("mul32_hi", 64'hFFFF_FFFE);
    expect_v("mul32_lo", 64'h0000_0001);
    expect_v("mul32_div0", 0);
    run_md(1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk(64'(cyc)); chk(hi32); chk(lo32); chk(div0_32);
    ev32 = 1'b0;
    tick();

    // MFHI after completion
    aluOp = 4'b0000; func = F_MFHI; ev32 = 1'b1;
    #1;
    expect_v("mfhi_out", 64'h8);         chk(out32);
    expect_v("mfhi_stall", 0);           chk(stall32);
    expect_v("mfhi_hi", 64'hFFFF_FFFE);  chk(hi32);
    ev32 = 1'b0;
    tick();

    // Reset during BUSY cycle 10 of a DIVU
    aluOp = 4'b0000; func = F_DIVU; a32 = 32'd1000; b32 = 32'd3; ev32 = 1'b1;
    #1;
    repeat (10) tick();
    expect_v("rstmid_busy_stall", 1); chk(stall32);
    rst32_n = 1'b0; ev32 = 1'b0;
    tick();
    expect_v("rstmid_stall", 0); chk(stall32);
    expect_v("rstmid_hi", 0);    chk(hi32);
    expect_v("rstmid_lo", 0);    chk(lo32);
    expect_v("rstmid_div0", 0);  chk(div0_32);
    rst32_n = 1'b1;
    repeat (40) tick();
    expect_v("rstmid_late_hi", 0); chk(hi32);
    expect_v("rstmid_late_lo", 0); chk(lo32);

    // DIVU 200 / 7 on the 8-bit instance
    expect_v("div8_stall", 9);
    expect_v("div8_lo", 28);
    expect_v("div8_hi", 4);
    expect_v("div8_div0", 0);
    run_md(1'b1, F_DIVU, 32'd200, 32'd7, cyc);
    chk(64'(cyc)); chk(lo8); chk(hi8); chk(div0_8);
    ev8 = 1'b0;
    tick();

    // DIVU 0x55 / 0
    expect_v("dz_stall", 9);
    expect_v("dz_lo", 64'hFF);
    expect_v("dz_hi", 64'h55);
    expect_v("dz_div0", 1);
    run_md(1'b1, F_DIVU, 32'h55, 32'd0, cyc);
    chk(64'(cyc)); chk(lo8); chk(hi8); chk(div0_8);
    ev8 = 1'b0;
    tick();

    // Back-to-back: MULTU 12x11 then DIVU 100/9 in the cycle after DONE
    expect_v("b2b_mul_stall", 9);
    expect_v("b2b_mul_hi", 0);
    expect_v("b2b_mul_lo", 132);
    expect_v("b2b_mul_div0", 0);
    run_md(1'b1, F_MULTU, 32'd12, 32'd11, cyc);
    chk(64'(cyc)); chk(hi8); chk(lo8); chk(div0_8);
    tick();
    expect_v("b2b_div_stall", 9);
    expect_v("b2b_div_lo", 11);
    expect_v("b2b_div_hi", 1);
    expect_v("b2b_div_div0", 0);
    run_md(1'b1, F_DIVU, 32'd100, 32'd9, cyc);
    chk(64'(cyc)); chk(lo8); chk(hi8); chk(div0_8);
    tick();
    aluOp = 4'b0000; func = F_MFLO;
    #1;
    expect_v("mflo_out", 64'h9);  chk(out8);
    expect_v("mflo_lo", 11);      chk(lo8);
    expect_v("mflo_stall", 0);    chk(stall8);
    ev8 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
